// File: rtl/ram_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_scan_pkg
//  Description : Shared types and default constants for the RAM scan reader
//                and its tick counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_scan_pkg;

    // One second at the 50 MHz board clock
    localparam int c_CYCLES_1S_50MHZ = 50_000_000;

    // Default configuration for the ram32x4 lab RAM
    localparam int c_ADDR_W      = 5;
    localparam int c_DATA_W      = 4;
    localparam int c_RD_LAT      = 1;
    localparam int c_TICK_CYCLES = c_CYCLES_1S_50MHZ;

    // Scan FSM encoding
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ISSUE = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_SHOW  = 3'd3;
    localparam logic [2:0] c_ST_HOLD  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = c_ST_IDLE,
        ISSUE = c_ST_ISSUE,
        WAIT  = c_ST_WAIT,
        SHOW  = c_ST_SHOW,
        HOLD  = c_ST_HOLD
    } scan_state_e;

endpackage : ram_scan_pkg
`default_nettype wire

// File: rtl/tick_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tick_counter
//  Description : Free-running period counter. Counts while run is high,
//                wraps after TICK_CYCLES counts; done flags the last count.
//                clear has priority over run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_counter
    import ram_scan_pkg::*;
#(
    parameter int TICK_CYCLES = c_TICK_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic done
);

    // A single-cycle period still needs a one-bit register
    localparam int                 c_CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TICK_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;

    // Count up while running, wrap to zero after the last count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= (r_count == c_LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign done = (r_count == c_LAST);

endmodule : tick_counter
`default_nettype wire

// File: rtl/ram_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_scan_reader
//  Description : Read-side scanner for the ram32x4 lab RAM. Walks the read
//                address one location per display period, waits out the RAM
//                read latency, and latches word + address for the HEX/LED
//                display. Writes (wr_busy) pause the scan and force a
//                re-read of the current address.
//                Optional macro RAM_SCAN_STEP_EN adds a 'step' input whose
//                rising edge skips the remainder of the display period.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_scan_reader
    import ram_scan_pkg::*;
#(
    parameter int ADDR_W      = c_ADDR_W,
    parameter int DATA_W      = c_DATA_W,
    parameter int RD_LAT      = c_RD_LAT,
    parameter int TICK_CYCLES = c_TICK_CYCLES
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              wr_busy,
`ifdef RAM_SCAN_STEP_EN
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              disp_strobe,
    output logic              wrap
);

    localparam int                 c_LAT_W     = $clog2(RD_LAT + 1);
    localparam logic [c_LAT_W-1:0] c_LAT_LOAD  = c_LAT_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0]  c_ADDR_LAST = {ADDR_W{1'b1}};

    scan_state_e         r_state;
    logic [ADDR_W-1:0]   r_scan_addr;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W-1:0]   r_disp_addr;
    logic [DATA_W-1:0]   r_disp_data;
    logic                r_disp_valid;
    logic                r_disp_strobe;
    logic                r_wrap;
    logic [c_LAT_W-1:0]  r_lat_cnt;

    logic                w_tick_done;
    logic                w_tick_run;
    logic                w_tick_clear;
    logic                w_advance;

    // The tick only runs while a word is on display; any other state
    // discards the partial count so each display period starts fresh.
    assign w_tick_run   = (r_state == SHOW);
    assign w_tick_clear = (r_state != SHOW);

    tick_counter #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (w_tick_clear),
        .run     (w_tick_run),
        .done    (w_tick_done)
    );

`ifdef RAM_SCAN_STEP_EN
    logic r_step_d;
    logic w_step_rise;

    // Delay step by one cycle for rising-edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= step;
        end
    end

    assign w_step_rise = step & ~r_step_d;
    assign w_advance   = w_tick_done | w_step_rise;
`else
    assign w_advance   = w_tick_done;
`endif

    // Scan FSM plus capture registers; enable beats wr_busy beats expiry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_scan_addr   <= '0;
            r_rd_addr     <= '0;
            r_disp_addr   <= '0;
            r_disp_data   <= '0;
            r_disp_valid  <= 1'b0;
            r_disp_strobe <= 1'b0;
            r_wrap        <= 1'b0;
            r_lat_cnt     <= '0;
        end else begin
            r_disp_strobe <= 1'b0;
            r_wrap        <= 1'b0;
            if (!enable) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!wr_busy) r_state <= ISSUE;
                    end
                    ISSUE: begin
                        if (wr_busy) begin
                            r_state <= HOLD;
                        end else begin
                            r_lat_cnt <= c_LAT_LOAD;
                            r_state   <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (wr_busy) begin
                            r_state <= HOLD;
                        end else if (r_lat_cnt == '0) begin
                            r_disp_data   <= rd_data;
                            r_disp_addr   <= r_scan_addr;
                            r_disp_valid  <= 1'b1;
                            r_disp_strobe <= 1'b1;
                            r_state       <= SHOW;
                        end else begin
                            r_lat_cnt <= r_lat_cnt - 1'b1;
                        end
                    end
                    SHOW: begin
                        if (wr_busy) begin
                            r_state <= HOLD;
                        end else if (w_advance) begin
                            r_scan_addr <= r_scan_addr + 1'b1;
                            r_rd_addr   <= r_scan_addr + 1'b1;
                            r_wrap      <= (r_scan_addr == c_ADDR_LAST);
                            r_state     <= ISSUE;
                        end
                    end
                    HOLD: begin
                        // Re-read the same address once the write is over
                        if (!wr_busy) r_state <= ISSUE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rd_addr     = r_rd_addr;
    assign disp_addr   = r_disp_addr;
    assign disp_data   = r_disp_data;
    assign disp_valid  = r_disp_valid;
    assign disp_strobe = r_disp_strobe;
    assign wrap        = r_wrap;

endmodule : ram_scan_reader
`default_nettype wire

// File: tb/tb_ram_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_scan_reader
//  Description : Self-checking bench for ram_scan_reader with a behavioural
//                RAM and a timeline-based expectation of each capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_scan_reader;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;
    localparam int RD_LAT = 1;
    localparam int TICK   = 4;
    localparam int N_ADDR = 1 << ADDR_W;
    // Capture-to-capture spacing: display period + one issue cycle + latency
    localparam int PERIOD = TICK + 1 + RD_LAT;
    // From IDLE/HOLD to capture: leave the state, issue, then latency
    localparam int RESTART = 2 + RD_LAT;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              enable;
    logic              wr_busy;
`ifdef RAM_SCAN_STEP_EN
    logic              step;
`endif
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              disp_strobe;
    logic              wrap;

    logic [DATA_W-1:0] mem [N_ADDR];
    logic [DATA_W-1:0] ram_q;

    int                n_checks = 0;
    int                n_errors = 0;
    int                wrap_cnt = 0;
    logic [ADDR_W-1:0] wrap_rd;

    ram_scan_reader #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .RD_LAT      (RD_LAT),
        .TICK_CYCLES (TICK)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .wr_busy     (wr_busy),
`ifdef RAM_SCAN_STEP_EN
        .step        (step),
`endif
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .disp_valid  (disp_valid),
        .disp_strobe (disp_strobe),
        .wrap        (wrap)
    );

    always #5 clock = ~clock;

    // Synchronous RAM read port, one edge of latency
    always @(posedge clock) ram_q <= mem[rd_addr];
    assign rd_data = ram_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge
    task automatic cyc();
        @(posedge clock);
        #1;
        if (wrap === 1'b1) begin
            wrap_cnt++;
            wrap_rd = rd_addr;
        end
    endtask

    task automatic wait_strobe(input int budget, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (disp_strobe !== 1'b1 && n < budget);
        chk("strobe_seen", 32'(disp_strobe), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int                n;
    int                act;
    int                d;
    int                len;
    logic [ADDR_W-1:0] exp_a;
    logic [ADDR_W-1:0] last_a;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        wr_busy = 1'b0;
`ifdef RAM_SCAN_STEP_EN
        step    = 1'b0;
`endif
        for (int a = 0; a < N_ADDR; a++) mem[a] = DATA_W'(a);
        repeat (3) cyc();

        // Reset values
        chk("rst_rd_addr",     32'(rd_addr), 0);
        chk("rst_disp_addr",   32'(disp_addr), 0);
        chk("rst_disp_data",   32'(disp_data), 0);
        chk("rst_disp_valid",  32'(disp_valid), 0);
        chk("rst_disp_strobe", 32'(disp_strobe), 0);
        chk("rst_wrap",        32'(wrap), 0);

        reset_n = 1'b1;
        cyc();
        chk("idle_no_valid", 32'(disp_valid), 0);

        // Basic scan: first capture, then hold period, then next address
        enable = 1'b1;
        wait_strobe(20, n);
        chk("first_latency", n, RESTART);
        chk("first_addr",    32'(disp_addr), 0);
        chk("first_data",    32'(disp_data), 32'(mem[0]));
        chk("first_valid",   32'(disp_valid), 1);
        chk("first_rd_addr", 32'(rd_addr), 0);
        n = 0;
        do begin
            cyc();
            n++;
        end while (rd_addr == 0 && n < 20);
        chk("hold_cycles",    n, TICK);
        chk("rd_addr_adv",    32'(rd_addr), 1);
        chk("disp_addr_kept", 32'(disp_addr), 0);
        wait_strobe(20, n);
        chk("issue_to_cap", n, RD_LAT + 1);
        chk("second_addr",  32'(disp_addr), 1);
        chk("second_data",  32'(disp_data), 32'(mem[1]));

        // Full scan through the wrap point back to address 0
        wrap_cnt = 0;
        for (int k = 2; k <= N_ADDR; k++) begin
            wait_strobe(20, n);
            chk("scan_period", n, PERIOD);
            chk("scan_addr",   32'(disp_addr), k % N_ADDR);
            chk("scan_data",   32'(disp_data), 32'(mem[k % N_ADDR]));
        end
        chk("wrap_count",   wrap_cnt, 1);
        chk("wrap_rd_addr", 32'(wrap_rd), 0);

        // Write during WAIT at address 5
        for (int k = 1; k <= 4; k++) begin
            wait_strobe(20, n);
            chk("pre_wr_addr", 32'(disp_addr), k);
        end
        repeat (TICK) cyc();
        chk("wr_rd_addr", 32'(rd_addr), 5);
        cyc();
        wr_busy = 1'b1;
        mem[5]  = 4'hA;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("busy_no_strobe", 32'(disp_strobe), 0);
            chk("busy_disp_addr", 32'(disp_addr), 4);
        end
        wr_busy = 1'b0;
        wait_strobe(20, n);
        chk("reissue_latency", n, RESTART);
        chk("reissue_addr",    32'(disp_addr), 5);
        chk("reissue_data",    32'(disp_data), 32'hA);
        wait_strobe(20, n);
        chk("after_wr_period", n, PERIOD);
        chk("after_wr_addr",   32'(disp_addr), 6);
        chk("after_wr_data",   32'(disp_data), 32'(mem[6]));

        // Disable in SHOW at address 7, then resume
        wait_strobe(20, n);
        chk("pre_dis_addr", 32'(disp_addr), 7);
        cyc();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("dis_no_strobe", 32'(disp_strobe), 0);
        end
        chk("dis_disp_addr",  32'(disp_addr), 7);
        chk("dis_rd_addr",    32'(rd_addr), 7);
        chk("dis_disp_valid", 32'(disp_valid), 1);
        enable = 1'b1;
        wait_strobe(20, n);
        chk("resume_latency", n, RESTART);
        chk("resume_addr",    32'(disp_addr), 7);
        chk("resume_data",    32'(disp_data), 32'(mem[7]));
        wait_strobe(20, n);
        chk("resume_period",  n, PERIOD);
        chk("resume_next",    32'(disp_addr), 8);

        // Random writes / disables at random points in the display period.
        // An interruption seen before the tick expires re-reads the shown
        // address; from the expiry edge on the address has already moved.
        last_a = 8;
        for (int it = 0; it < 40; it++) begin
            act   = $urandom_range(0, 2);
            d     = $urandom_range(0, PERIOD - 1);
            len   = $urandom_range(1, 3);
            exp_a = last_a + 1'b1;
            if (act != 0) begin
                repeat (d) cyc();
                if (act == 1) begin
                    wa      = ADDR_W'($urandom_range(0, N_ADDR - 1));
                    wd      = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
                    mem[wa] = wd;
                    wr_busy = 1'b1;
                end else begin
                    enable = 1'b0;
                end
                repeat (len) cyc();
                wr_busy = 1'b0;
                enable  = 1'b1;
                if (d < TICK) exp_a = last_a;
            end
            wait_strobe(40, n);
            chk("rand_addr", 32'(disp_addr), 32'(exp_a));
            chk("rand_data", 32'(disp_data), 32'(mem[exp_a]));
            last_a = exp_a;
        end

        // Asynchronous reset in the middle of WAIT
        repeat (TICK) cyc();
        cyc();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_rd_addr",     32'(rd_addr), 0);
        chk("arst_disp_addr",   32'(disp_addr), 0);
        chk("arst_disp_data",   32'(disp_data), 0);
        chk("arst_disp_valid",  32'(disp_valid), 0);
        chk("arst_disp_strobe", 32'(disp_strobe), 0);
        chk("arst_wrap",        32'(wrap), 0);
        repeat (2) cyc();
        reset_n = 1'b1;
        wait_strobe(20, n);
        chk("post_rst_latency", n, RESTART);
        chk("post_rst_addr",    32'(disp_addr), 0);
        chk("post_rst_data",    32'(disp_data), 32'(mem[0]));

`ifdef RAM_SCAN_STEP_EN
        // Step pulse in SHOW advances on the very next edge
        cyc();
        step = 1'b1;
        cyc();
        step = 1'b0;
        chk("step_rd_addr", 32'(rd_addr), 1);
        wait_strobe(20, n);
        chk("step_latency", n, RD_LAT + 1);
        chk("step_addr",    32'(disp_addr), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ram_scan_reader
`default_nettype wire

// File: doc/ram_scan_reader.md
Name: ram_scan_reader

Overview:
- Read-side controller for the 32x4 single-port synchronous RAM (ram32x4) on the DE1-SoC. The write side is driven from switches and KEY.
- It walks the read address through every location, one address per display period, and waits out the RAM read latency.
- It latches each word plus its address for HEX/LED display, and pauses around writes so it never shows stale data.
- Sits between the RAM q port and the display decoders in the lab top level.

Parameters:
ADDR_W, 5, RAM address width; the scan wraps at 2**ADDR_W-1
DATA_W, 4, RAM data width
RD_LAT, 1, clock edges from RAM address sample to valid q (1 = unregistered q, 2 = registered q)
TICK_CYCLES, 50_000_000, clock cycles each captured word is held before advancing (1 s at 50 MHz)

Ports:
clock  in  1  system clock (CLOCK_50)
reset_n  in  1  asynchronous active-low reset
enable  in  1  scan run; low parks the FSM in IDLE
wr_busy  in  1  write side active (tie to RAM wren); blocks reads
rd_addr  out  ADDR_W  RAM read address; registered, always equals scan_addr
rd_data  in  DATA_W  RAM q
disp_addr  out  ADDR_W  address of the displayed word
disp_data  out  DATA_W  displayed word
disp_valid  out  1  level; high once any word has been captured since reset
disp_strobe  out  1  one-cycle pulse on every capture
wrap  out  1  one-cycle pulse when scan_addr advances from 2**ADDR_W-1 to 0

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - scan_addr, rd_addr, disp_addr, disp_data, tick counter and latency counter all 0.
  - disp_valid, disp_strobe and wrap all 0.
- States: IDLE, ISSUE, WAIT, SHOW, HOLD.
- IDLE: when enable=1 and wr_busy=0, go to ISSUE.
- ISSUE: exactly one cycle, during which the RAM samples rd_addr. Load the latency counter with RD_LAT-1, then go to WAIT.
- WAIT: decrement the latency counter each cycle. At 0:
  - capture disp_data<=rd_data and disp_addr<=scan_addr;
  - set disp_valid<=1 and pulse disp_strobe;
  - clear the tick counter and go to SHOW.
- Capture edge = RD_LAT+1 rising edges after rd_addr changes.
- SHOW: increment the tick counter. At TICK_CYCLES-1:
  - scan_addr<=scan_addr+1, modulo 2**ADDR_W; pulse wrap if the old value was all-ones;
  - go to ISSUE.
  - rd_addr tracks scan_addr on the same edge.
- wr_busy=1 in ISSUE or WAIT: abort with no capture and go to HOLD.
- wr_busy=1 in SHOW: go to HOLD; the tick count is discarded.
- HOLD: wait for wr_busy=0, then go to ISSUE with scan_addr unchanged. This re-reads the current address so a just-written value is displayed.
- enable=0 in any state: go to IDLE next cycle. scan_addr, disp_* and disp_valid are retained. Resume restarts at ISSUE for the same address.
- Priority when inputs coincide: enable=0 > wr_busy=1 > tick/latency expiry. The address does not advance on a cycle where wr_busy also rises.
- disp_data/disp_addr change only on a capture edge. Outputs are glitch-free (all registered).
- Widths: tick counter is $clog2(TICK_CYCLES) bits; latency counter is $clog2(RD_LAT+1) bits. Address arithmetic is unsigned and wraps naturally.
- Mid-operation reset: returns immediately to the reset values. No capture occurs on the reset-release edge.

Optional Feature:
- Macro: RAM_SCAN_STEP_EN.
- Defined:
  - adds input step (1 bit, synchronous, e.g. debounced ~KEY[1]);
  - a rising edge of step while in SHOW advances immediately, as if the tick expired;
  - a rising edge in other states is ignored;
  - edge detection uses one internal register that resets to 0.
- Undefined: no step port, no edge register; advance is by tick only.

Decomposition:
- Package ram_scan_pkg holds:
  - the state enum typedef (scan_state_e: IDLE, ISSUE, WAIT, SHOW, HOLD);
  - default constants for ADDR_W, DATA_W, RD_LAT and TICK_CYCLES;
  - the 50 MHz one-second cycle constant.
- One sub-module is natural: tick_counter (parameter TICK_CYCLES; inputs clear, run; output done at count TICK_CYCLES-1). It is reusable for other lab timers.
- The FSM and the capture registers stay in ram_scan_reader.

Test Plan:
- Bench setup: TICK_CYCLES=4, RD_LAT=1, behavioural RAM model preloaded with mem[a]=a[3:0].
- Basic scan: release reset, enable=1 -> rd_addr=0; disp_data=0 and disp_strobe on the 2nd edge after ISSUE; rd_addr=1 four cycles later; disp_data=1.
- Wrap: run a full scan -> disp_addr sequence 0..31,0; wrap pulses once as rd_addr goes 31->0; disp_data[k]=k mod 16.
- Write during WAIT: wr_busy=1 for 3 cycles during WAIT at address 5 while writing 4'hA -> no strobe while busy; re-issue at 5; disp_data=4'hA; scan continues at 6.
- Disable/resume: enable=0 in SHOW at address 7 -> IDLE, disp_addr stays 7 and rd_addr stays 7; enable=1 -> re-read 7, then advance to 8.
- Reset mid-WAIT: reset_n pulsed low -> all outputs 0 immediately, disp_valid=0; the first capture after release is address 0.
- With RAM_SCAN_STEP_EN, RD_LAT=2: step pulse in SHOW at address 3 -> next ISSUE on the following cycle; capture of address 4 is 3 edges after rd_addr=4.
